// File: rtl/pipe_pkg.sv
// Shared pipeline constants: stage-bus widths used by every inter-stage buffer instance.
package pipe_pkg;

  localparam int unsigned IF2ID_W  = 32'd64;
  localparam int unsigned ID2EX_W  = 32'd158;
  localparam int unsigned EX2MEM_W = 32'd138;
  localparam int unsigned MEM2WB_W = 32'd70;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 32'd0) && ((n & (n - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/pipe_fifo_mem.sv
// DEPTH x WIDTH storage array for the stage FIFO: one write port, asynchronous read port.
module pipe_fifo_mem
  import pipe_pkg::*;
#(
  parameter  int unsigned WIDTH = IF2ID_W,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Entry write; every entry clears on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// Inter-stage FIFO buffer with valid/allowin handshakes. in_allowin comes only from
// registered occupancy, which cuts the combinational allowin chain between stages.
module pipe_stage_fifo
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = IF2ID_W,
  parameter int unsigned DEPTH  = 4,
  parameter bit          BYPASS = 1'b0,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_allowin,
  input  logic [WIDTH-1:0] in_bus,
  output logic             out_valid,
  input  logic             out_allowin,
  output logic [WIDTH-1:0] out_bus,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  if ((DEPTH < 32'd2) || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("pipe_stage_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             full_r, empty_r;
  logic             push_s, pop_s, bypass_s, store_s, deq_s;
  logic [WIDTH-1:0] rd_data_s;

  assign in_allowin = ~full_r;
  assign bypass_s   = BYPASS & empty_r;
  assign push_s     = in_valid & in_allowin & ~flush;
  assign pop_s      = out_valid & out_allowin & ~flush;
  // A beat that passes straight through an empty bypass FIFO never touches storage.
  assign store_s    = push_s & ~(bypass_s & pop_s);
  assign deq_s      = pop_s & ~bypass_s;

  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;

  pipe_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (store_s),
    .wr_addr (wr_ptr_r),
    .wr_data (in_bus),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Head select: an empty bypass FIFO forwards the upstream beat in the same cycle.
  always_comb begin
    out_valid = 1'b0;
    out_bus   = {WIDTH{1'b0}};
    if (bypass_s) begin
      out_valid = in_valid & ~flush;
      out_bus   = in_bus;
    end else begin
      out_valid = ~empty_r;
      out_bus   = rd_data_s;
    end
  end

  // Next occupancy from the stored-entry enqueue/dequeue pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({store_s, deq_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer/occupancy state; flush returns to the empty state without clearing storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (store_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (deq_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_DEPTH);
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Scoreboard bench: a normal (dut_a) and a bypass (dut_b) instance share one stimulus
// stream; each has its own reference queue.
module tb_pipe_stage_fifo;
  import pipe_pkg::*;

  localparam int W  = IF2ID_W;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic          clk, resetn, flush, in_valid, out_allowin;
  logic [W-1:0]  in_bus;
  logic          a_in_allowin, a_out_valid, a_full, a_empty;
  logic [W-1:0]  a_out_bus;
  logic [CW-1:0] a_count;
  logic          b_in_allowin, b_out_valid, b_full, b_empty;
  logic [W-1:0]  b_out_bus;
  logic [CW-1:0] b_count;

  logic [W-1:0]  qa[$];
  logic [W-1:0]  qb[$];
  int            checks = 0;
  int            errors = 0;

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b0)) dut_a (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_allowin(a_in_allowin), .in_bus(in_bus),
    .out_valid(a_out_valid), .out_allowin(out_allowin), .out_bus(a_out_bus),
    .count(a_count), .full(a_full), .empty(a_empty)
  );

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_allowin(b_in_allowin), .in_bus(in_bus),
    .out_valid(b_out_valid), .out_allowin(out_allowin), .out_bus(b_out_bus),
    .count(b_count), .full(b_full), .empty(b_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive, check mid-cycle against the models, clock, update models.
  task automatic cycle(input logic iv, input logic [W-1:0] d, input logic oa, input logic fl);
    logic         a_v, b_v, a_push, a_pop, b_push, b_pop;
    logic [W-1:0] b_head;
    in_valid = iv; in_bus = d; out_allowin = oa; flush = fl;
    #4;
    a_v = (qa.size() != 0);
    chk("a_valid",   a_out_valid,  a_v);
    chk("a_count",   a_count,      qa.size());
    chk("a_full",    a_full,       qa.size() == D);
    chk("a_empty",   a_empty,      qa.size() == 0);
    chk("a_allowin", a_in_allowin, qa.size() < D);
    if (a_v) chk("a_bus", a_out_bus, qa[0]);
    b_v    = (qb.size() != 0) || (iv && !fl);
    b_head = (qb.size() != 0) ? qb[0] : d;
    chk("b_valid",   b_out_valid,  b_v);
    chk("b_count",   b_count,      qb.size());
    chk("b_full",    b_full,       qb.size() == D);
    chk("b_empty",   b_empty,      qb.size() == 0);
    chk("b_allowin", b_in_allowin, qb.size() < D);
    if (b_v) chk("b_bus", b_out_bus, b_head);
    a_push = iv && (qa.size() < D) && !fl;
    a_pop  = a_v && oa && !fl;
    b_push = iv && (qb.size() < D) && !fl;
    b_pop  = b_v && oa && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      qa.delete();
    end else begin
      if (a_pop)  void'(qa.pop_front());
      if (a_push) qa.push_back(d);
    end
    if (fl) begin
      qb.delete();
    end else if (!((qb.size() == 0) && b_push && b_pop)) begin
      if (b_pop)  void'(qb.pop_front());
      if (b_push) qb.push_back(d);
    end
  endtask

  task automatic reset_check();
    chk("rst_a_valid",   a_out_valid,  1'b0);
    chk("rst_a_bus",     a_out_bus,    {W{1'b0}});
    chk("rst_a_count",   a_count,      {CW{1'b0}});
    chk("rst_a_empty",   a_empty,      1'b1);
    chk("rst_a_full",    a_full,       1'b0);
    chk("rst_a_allowin", a_in_allowin, 1'b1);
    chk("rst_b_valid",   b_out_valid,  1'b0);
    chk("rst_b_count",   b_count,      {CW{1'b0}});
    chk("rst_b_empty",   b_empty,      1'b1);
  endtask

  initial begin
    resetn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b0; in_bus = {W{1'b0}};
    #2 resetn = 1'b0;
    #1 reset_check();
    @(posedge clk); @(posedge clk);
    #1 resetn = 1'b1;

    // Idle after reset.
    cycle(1'b0, 64'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b0);

    // Fill to full, refused fifth push, then drain in order.
    cycle(1'b1, 64'h11, 1'b0, 1'b0);
    cycle(1'b1, 64'h22, 1'b0, 1'b0);
    cycle(1'b1, 64'h33, 1'b0, 1'b0);
    cycle(1'b1, 64'h44, 1'b0, 1'b0);
    cycle(1'b1, 64'h55, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Steady stream 1..10, pointers wrap twice.
    for (int i = 1; i <= 10; i++) cycle(1'b1, 64'(i), 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Flush with a same-cycle push and pop request.
    cycle(1'b1, 64'hA1, 1'b0, 1'b0);
    cycle(1'b1, 64'hA2, 1'b0, 1'b0);
    cycle(1'b1, 64'hA3, 1'b0, 1'b0);
    cycle(1'b1, 64'hAA, 1'b1, 1'b1);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Bypass pass-through, then a held beat when downstream stalls.
    cycle(1'b1, 64'h5A, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b1, 64'h5A, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b0, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);
    cycle(1'b0, 64'h0, 1'b1, 1'b0);

    // Random traffic with an asynchronous reset landing mid-burst.
    for (int n = 0; n < 10000; n++) begin
      if (n == 5000) begin
        cycle(1'b1, 64'hC1, 1'b0, 1'b0);
        cycle(1'b1, 64'hC2, 1'b0, 1'b0);
        cycle(1'b1, 64'hC3, 1'b0, 1'b0);
        in_valid = 1'b0; out_allowin = 1'b0; flush = 1'b0;
        #2 resetn = 1'b0;
        #1 reset_check();
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
      end
      cycle(($urandom_range(3, 0) != 0), {$urandom, $urandom},
            ($urandom_range(2, 0) != 0), ($urandom_range(63, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
